// File: rtl/pow2_accum.sv
// pow2_accum: sums 2^-d terms over a vector, then normalizes the sum to 1.mant x 2^exp.
// Optional ACCUM_SAT_EN: saturate the accumulator at 0xFFFFF instead of wrapping on overflow.
module pow2_accum #(
   parameter int MANT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_d,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [MANT_WIDTH-1:0] out_mant,
   output logic [5:0]            out_exp,
   output logic                  out_zero,
   output logic                  out_valid,
   input  logic                  out_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_NORM  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                state_q;
   logic [19:0]           acc_q;
   logic [19:0]           acc_d;
   logic [4:0]            shift_q;
   logic [MANT_WIDTH-1:0] mant_q;
   logic [5:0]            exp_q;
   logic                  zero_q;
   logic                  valid_q;

   logic [3:0]            di_s;
   logic [3:0]            df_s;
   logic [15:0]           base_s;
   logic [15:0]           term_s;
   logic [19:0]           acc_base_s;
   logic                  beat_s;
`ifdef ACCUM_SAT_EN
   logic [20:0]           sum_s;
`endif

   // Reset overrides the state decode so no beat can be offered while rst is held.
   assign in_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
   assign beat_s   = in_valid & in_ready;

   // Term generation and accumulate/load of the next accumulator value.
   always_comb begin
      di_s       = in_d[7:4];
      df_s       = in_d[3:0];
      base_s     = 16'd32768 - {2'b00, df_s, 10'd0};
      term_s     = base_s >> di_s;
      acc_base_s = (state_q == ST_IDLE) ? 20'd0 : acc_q;
`ifdef ACCUM_SAT_EN
      sum_s = {1'b0, acc_base_s} + {5'd0, term_s};
      if (sum_s[20]) begin
         acc_d = 20'hFFFFF;
      end else begin
         acc_d = sum_s[19:0];
      end
`else
      acc_d = acc_base_s + {4'd0, term_s};
`endif
   end

   // Control FSM with registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= 20'd0;
         shift_q <= 5'd0;
         mant_q  <= '0;
         exp_q   <= 6'd0;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (beat_s) begin
                  acc_q   <= acc_d;
                  shift_q <= 5'd0;
                  state_q <= in_last ? ST_NORM : ST_ACCUM;
               end
            end
            ST_NORM: begin
               if (acc_q == 20'd0) begin
                  zero_q  <= 1'b1;
                  mant_q  <= '0;
                  exp_q   <= 6'd0;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else if (acc_q[19]) begin
                  zero_q  <= 1'b0;
                  mant_q  <= acc_q[18 -: MANT_WIDTH];
                  exp_q   <= 6'd4 - {1'b0, shift_q};
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  acc_q   <= {acc_q[18:0], 1'b0};
                  shift_q <= shift_q + 5'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_mant  = mant_q;
   assign out_exp   = exp_q;
   assign out_zero  = zero_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_pow2_accum.sv
// tb_pow2_accum: scoreboard bench; expected results are modelled when a vector is driven
// and compared when the result handshake completes.
module tb_pow2_accum;

   logic       clk;
   logic       rst;
   logic [7:0] in_d;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] out_mant;
   logic [5:0] out_exp;
   logic       out_zero;
   logic       out_valid;
   logic       out_ready;

   typedef struct {
      logic       zero;
      logic [5:0] expo;
      logic [7:0] mant;
      int         lat;
   } res_t;

   res_t       sb[$];
   logic [7:0] vec[0:63];
   int         vec_len;
   int         n_checks;
   int         n_pass;

   pow2_accum #(.MANT_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_d      (in_d),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_mant  (out_mant),
      .out_exp   (out_exp),
      .out_zero  (out_zero),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end else begin
         n_pass++;
      end
   endtask

   function automatic res_t model_vec();
      logic [20:0] acc;
      logic [15:0] term;
      logic [19:0] norm;
      int          p;
      int          shifts;
      res_t        r;
      acc = 21'd0;
      for (int i = 0; i < vec_len; i++) begin
         term = 16'((32768 - 1024 * int'(vec[i][3:0])) >> vec[i][7:4]);
         acc  = acc + {5'd0, term};
`ifdef ACCUM_SAT_EN
         if (acc[20]) acc = 21'h0FFFFF;
`else
         acc[20] = 1'b0;
`endif
      end
      r.zero = 1'b0;
      r.expo = 6'd0;
      r.mant = 8'd0;
      if (acc == 21'd0) begin
         r.zero = 1'b1;
         r.lat  = 1;
      end else begin
         p = 0;
         for (int b = 0; b < 20; b++) begin
            if (acc[b]) p = b;
         end
         shifts = 19 - p;
         norm   = acc[19:0] << shifts;
         r.expo = 6'(4 - shifts);
         r.mant = norm[18:11];
         r.lat  = shifts + 1;
      end
      return r;
   endfunction

   task automatic drive_beat(input logic [7:0] d, input logic last);
      int w;
      in_d     = d;
      in_last  = last;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) check_eq("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Pushes the modelled result (when the vector is terminated) and drives its beats.
   task automatic send_vector(input bit terminate);
      if (terminate) sb.push_back(model_vec());
      for (int i = 0; i < vec_len; i++) begin
         drive_beat(vec[i], terminate && (i == vec_len - 1));
      end
   endtask

   task automatic await_result(input int stall);
      int   cnt;
      res_t e;
      cnt = 0;
      while (!out_valid && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (!out_valid) begin
         check_eq("out_valid_timeout", 32'd0, 32'd1);
         if (sb.size() > 0) void'(sb.pop_front());
         out_ready = 1'b1;
         return;
      end
      if (sb.size() == 0) begin
         check_eq("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check_eq("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
      check_eq("out_exp",  {26'd0, out_exp},  {26'd0, e.expo});
      check_eq("out_mant", {24'd0, out_mant}, {24'd0, e.mant});
      check_eq("norm_latency", cnt, e.lat);
      if (stall > 0) begin
         // Offer a beat while stalled; it must be ignored.
         in_d     = 8'h00;
         in_last  = 1'b1;
         in_valid = 1'b1;
         for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_eq("stall_valid",    {31'd0, out_valid}, 32'd1);
            check_eq("stall_in_ready", {31'd0, in_ready},  32'd0);
            check_eq("stall_zero",     {31'd0, out_zero},  {31'd0, e.zero});
            check_eq("stall_exp",      {26'd0, out_exp},   {26'd0, e.expo});
            check_eq("stall_mant",     {24'd0, out_mant},  {24'd0, e.mant});
         end
         in_valid  = 1'b0;
         in_last   = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check_eq("release_valid",    {31'd0, out_valid}, 32'd0);
      check_eq("release_in_ready", {31'd0, in_ready},  32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
      check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      check_eq({tag, "_out_zero"},  {31'd0, out_zero},  32'd0);
      check_eq({tag, "_out_mant"},  {24'd0, out_mant},  32'd0);
      check_eq({tag, "_out_exp"},   {26'd0, out_exp},   32'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      in_d      = 8'h00;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      vec_len   = 0;
      #13;
      check_reset_state("por");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Single beat of 1.0.
      vec[0] = 8'h00; vec_len = 1;
      send_vector(1'b1); await_result(0);

      // 1 - 0.25 = 0.75.
      vec[0] = 8'h08; vec_len = 1;
      send_vector(1'b1); await_result(0);

      // Smallest terms: 1 then 0.
      vec[0] = 8'hF0; vec[1] = 8'hFF; vec_len = 2;
      send_vector(1'b1); await_result(0);

      vec[0] = 8'hFF; vec_len = 1;
      send_vector(1'b1); await_result(0);

      // 32 x 1.0 overflows the accumulator.
      for (int i = 0; i < 32; i++) vec[i] = 8'h00;
      vec_len = 32;
      send_vector(1'b1); await_result(0);

      // Stalled downstream with input offered during DONE.
      out_ready = 1'b0;
      vec[0] = 8'h10; vec[1] = 8'h23; vec_len = 2;
      send_vector(1'b1); await_result(10);

      // Fresh vector after the stall must not include the ignored beat.
      vec[0] = 8'h31; vec_len = 1;
      send_vector(1'b1); await_result(0);

      for (int t = 0; t < 6; t++) begin
         vec_len = $urandom_range(1, 6);
         for (int i = 0; i < vec_len; i++) vec[i] = 8'($urandom_range(0, 255));
         send_vector(1'b1); await_result(0);
      end

      // Leave non-zero results on the outputs, then reset mid-vector.
      vec[0] = 8'h08; vec_len = 1;
      send_vector(1'b1); await_result(0);
      vec[0] = 8'h12; vec[1] = 8'h05; vec[2] = 8'h40; vec_len = 3;
      send_vector(1'b0);
      #2 rst = 1'b1;
      #1;
      check_reset_state("midrst");
      @(negedge clk);
      rst = 1'b0;
      vec[0] = 8'h00; vec_len = 1;
      send_vector(1'b1); await_result(0);

      check_eq("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
